osd_avalon_burst_reader: RTL and testbench

Next-generation OSD bitmap fetch engine. It reads a packed pixel bitmap from memory through a pipelined, bursting Avalon-MM master and buffers the words in an internal FIFO. It then unpacks each word into 1/2/4/8-bit pixels and streams them out as one Avalon-ST packet per frame. It sits between the OSD frame-descriptor registers and the OSD overlay mixer.

---
 rtl/osd_avalon_burst_reader.sv | 183 ++++++++++++++++++
 tb/tb_osd_avalon_burst_reader.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/osd_avalon_burst_reader.sv
// OSD bitmap fetch engine: bursting Avalon-MM reads into a word FIFO, unpacked into
// 1/2/4/8-bit pixels and streamed out as one Avalon-ST packet per frame.
module osd_avalon_burst_reader #(
  parameter int unsigned DATA_LOG  = 5,
  parameter int unsigned PIX_LOG   = 0,
  parameter int unsigned BURST_LOG = 3,
  parameter int unsigned FIFO_LOG  = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [31:0]                     frame_addr,
  input  logic [31:0]                     frame_num,
  output logic                            busy,
  output logic                            done,
  output logic [31:0]                     am_address,
  output logic                            am_read,
  output logic [BURST_LOG:0]              am_burstcount,
  output logic [(1<<(DATA_LOG-3))-1:0]    am_byteenable,
  input  logic [(1<<DATA_LOG)-1:0]        am_readdata,
  input  logic                            am_readdatavalid,
  input  logic                            am_waitrequest,
  output logic [(1<<PIX_LOG)-1:0]         dout_data,
  output logic                            dout_valid,
  input  logic                            dout_ready,
  output logic                            dout_startofpacket,
  output logic                            dout_endofpacket
);

  localparam int unsigned DataW  = 1 << DATA_LOG;
  localparam int unsigned PixW   = 1 << PIX_LOG;
  localparam int unsigned PpwLog = DATA_LOG - PIX_LOG;
  localparam int unsigned Ppw    = 1 << PpwLog;
  localparam int unsigned IdxW   = (PpwLog > 0) ? PpwLog : 1;
  localparam int unsigned Depth  = 1 << FIFO_LOG;
  localparam int unsigned BeW    = 1 << (DATA_LOG - 3);
  localparam logic [31:0] ByteMask = 32'(BeW - 1);
  localparam logic [BURST_LOG:0] BurstMax = (BURST_LOG+1)'(1 << BURST_LOG);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StDrain} state_e;

  state_e              state_q, state_d;
  logic [31:0]         addr_q, addr_d;
  logic [31:0]         pix_left_q, pix_left_d;
  logic [31:0]         frame_num_q, frame_num_d;
  logic [32:0]         words_left_q, words_left_d;
  logic [FIFO_LOG:0]   outst_q, outst_d;
  logic [FIFO_LOG:0]   count_q, count_d;
  logic [FIFO_LOG-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_LOG-1:0] rd_ptr_q, rd_ptr_d;
  logic [IdxW-1:0]     pix_idx_q, pix_idx_d;
  logic                done_q, done_d;
  logic [DataW-1:0]    mem_q [Depth];

  logic [31:0]         off_bits, off_pix;
  logic [32:0]         pix_total, words_calc;
  logic [BURST_LOG:0]  next_bc;
  logic [FIFO_LOG+1:0] need;
  logic                room, accept, push, pop, xfer, last_pix, word_end;
  logic [DataW-1:0]    head_sh;

  assign off_bits   = (frame_addr & ByteMask) << 3;
  assign off_pix    = off_bits >> PIX_LOG;
  assign pix_total  = {1'b0, off_pix} + {1'b0, frame_num};
  assign words_calc = (pix_total + 33'(Ppw - 1)) >> PpwLog;

  assign next_bc = (words_left_q >= 33'(BurstMax)) ? BurstMax : words_left_q[BURST_LOG:0];
  // Reserve FIFO space for every word already in flight so a burst can never overflow it.
  assign need = (FIFO_LOG+2)'(count_q) + (FIFO_LOG+2)'(outst_q) + (FIFO_LOG+2)'(next_bc);
  assign room = need <= (FIFO_LOG+2)'(Depth);

  assign am_read       = (state_q == StReq);
  assign am_address    = addr_q;
  assign am_burstcount = am_read ? next_bc : '0;
  assign am_byteenable = am_read ? '1 : '0;
  assign accept        = am_read && !am_waitrequest;
  assign push          = am_readdatavalid;

  assign head_sh    = mem_q[rd_ptr_q] >> (32'(pix_idx_q) << PIX_LOG);
  assign dout_valid = (count_q != '0) && (pix_left_q != '0);
  assign last_pix   = (pix_left_q == 32'd1);
  assign word_end   = (pix_idx_q == IdxW'(Ppw - 1));
  assign xfer       = dout_valid && dout_ready;
  assign pop        = xfer && (word_end || last_pix);

  assign dout_data          = dout_valid ? head_sh[PixW-1:0] : '0;
  assign dout_startofpacket = dout_valid && (pix_left_q == frame_num_q);
  assign dout_endofpacket   = dout_valid && last_pix;
  assign busy               = (state_q != StIdle);
  assign done               = done_q;

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    pix_left_d   = pix_left_q;
    frame_num_d  = frame_num_q;
    words_left_d = words_left_q;
    pix_idx_d    = pix_idx_q;
    done_d       = 1'b0;
    wr_ptr_d     = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d     = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d      = count_q + (FIFO_LOG+1)'(push) - (FIFO_LOG+1)'(pop);
    outst_d      = outst_q + (accept ? (FIFO_LOG+1)'(next_bc) : '0) - (FIFO_LOG+1)'(push);

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (frame_num == '0) begin
            done_d = 1'b1;
          end else begin
            addr_d       = frame_addr & ~ByteMask;
            pix_left_d   = frame_num;
            frame_num_d  = frame_num;
            words_left_d = words_calc;
            pix_idx_d    = off_pix[IdxW-1:0];
            state_d      = StWait;
          end
        end
      end
      StReq: begin
        if (!am_waitrequest) begin
          addr_d       = addr_q + (32'(next_bc) << (DATA_LOG - 3));
          words_left_d = words_left_q - 33'(next_bc);
          state_d      = StWait;
        end
      end
      StWait: begin
        if (words_left_q == '0) begin
          state_d = StDrain;
        end else if (room) begin
          state_d = StReq;
        end
      end
      StDrain: ;
      default: state_d = StIdle;
    endcase

    if (xfer) begin
      pix_left_d = pix_left_q - 32'd1;
      pix_idx_d  = pop ? '0 : pix_idx_q + 1'b1;
      if (last_pix) begin
        state_d = StIdle;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      addr_q       <= '0;
      pix_left_q   <= '0;
      frame_num_q  <= '0;
      words_left_q <= '0;
      outst_q      <= '0;
      count_q      <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      pix_idx_q    <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      pix_left_q   <= pix_left_d;
      frame_num_q  <= frame_num_d;
      words_left_q <= words_left_d;
      outst_q      <= outst_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      pix_idx_q    <= pix_idx_d;
      done_q       <= done_d;
    end
  end

  // Storage needs no reset; emptiness is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= am_readdata;
    end
  end

endmodule

// File: tb/tb_osd_avalon_burst_reader.sv
// Scoreboard bench for osd_avalon_burst_reader: expected bursts and pixels are queued at
// stimulus time and popped by a negedge monitor as the DUT presents them.
module tb_osd_avalon_burst_reader;

  localparam int unsigned DATA_LOG = 5, PIX_LOG = 0, BURST_LOG = 3, FIFO_LOG = 4;
  localparam int unsigned PW = 1, PPW = 32, DEPTH = 16, MAXB = 8;

  logic        clk, rst_n, start;
  logic [31:0] frame_addr, frame_num;
  logic        busy, done;
  logic [31:0] am_address;
  logic        am_read;
  logic [BURST_LOG:0] am_burstcount;
  logic [3:0]  am_byteenable;
  logic [31:0] am_readdata;
  logic        am_readdatavalid, am_waitrequest;
  logic [PW-1:0] dout_data;
  logic        dout_valid, dout_ready, dout_sop, dout_eop;

  typedef struct packed {logic [PW-1:0] d; logic sop; logic eop;} pix_t;
  typedef struct packed {logic [31:0] a; logic [BURST_LOG:0] bc;} bur_t;

  pix_t        exp_q[$];
  bur_t        bur_q[$];
  logic [31:0] beat_q[$];
  int n_cmp = 0, n_err = 0;
  int mem_mode = 0, rdy_mode = 0, slv_rand = 0, gap = 0;
  int words_req = 0, xfers = 0, off_pix_tb = 0, acc_cnt = 0, done_cnt = 0;
  logic [31:0] mem_base = 0;
  logic        stalled_prev = 0;
  logic [PW+1:0] prev_out = '0;

  osd_avalon_burst_reader #(
    .DATA_LOG(DATA_LOG), .PIX_LOG(PIX_LOG), .BURST_LOG(BURST_LOG), .FIFO_LOG(FIFO_LOG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_addr(frame_addr), .frame_num(frame_num),
    .busy(busy), .done(done), .am_address(am_address), .am_read(am_read),
    .am_burstcount(am_burstcount), .am_byteenable(am_byteenable), .am_readdata(am_readdata),
    .am_readdatavalid(am_readdatavalid), .am_waitrequest(am_waitrequest),
    .dout_data(dout_data), .dout_valid(dout_valid), .dout_ready(dout_ready),
    .dout_startofpacket(dout_sop), .dout_endofpacket(dout_eop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (mem_mode == 1) return (a - mem_base) >> 2;
    return {a[7:0] ^ 8'h5A, a[15:8] ^ 8'hC3, ~a[7:0], a[11:4]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Ready and slave drivers update just after the active edge.
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: dout_ready = 1'b1;
      1: dout_ready = 1'($urandom_range(0, 1));
      default: dout_ready = 1'b0;
    endcase
    am_waitrequest = (slv_rand != 0) ? ($urandom_range(0, 2) == 0) : 1'b0;
    if (!rst_n) begin
      am_readdatavalid = 1'b0;
    end else if (gap > 0) begin
      gap--;
      am_readdatavalid = 1'b0;
    end else if (beat_q.size() > 0) begin
      am_readdata      = mem_word(beat_q.pop_front());
      am_readdatavalid = 1'b1;
      gap = (slv_rand != 0) ? int'($urandom_range(0, 9)) : 0;
    end else begin
      am_readdatavalid = 1'b0;
    end
  end

  // Monitor: decides what the next active edge will accept.
  always @(negedge clk) begin
    if (!rst_n) begin
      stalled_prev = 1'b0;
    end else begin
      if (am_read && !am_waitrequest) begin
        if (bur_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_burst: got addr %0h len %0d expected none", am_address,
                   am_burstcount);
        end else begin
          bur_t b;
          b = bur_q.pop_front();
          check("burst_addr", 64'(am_address), 64'(b.a));
          check("burst_len", 64'(am_burstcount), 64'(b.bc));
        end
        check("byteenable", 64'(am_byteenable), 64'hF);
        words_req += int'(am_burstcount);
        n_cmp++;
        if (words_req - (off_pix_tb + xfers) / PPW > DEPTH) begin
          n_err++;
          $display("FAIL fifo_room: got %0d words committed expected <= %0d",
                   words_req - (off_pix_tb + xfers) / PPW, DEPTH);
        end
        for (int i = 0; i < int'(am_burstcount); i++) beat_q.push_back(am_address + 32'(4 * i));
        acc_cnt++;
      end
      if (dout_valid && stalled_prev) check("stall_stable", 64'({dout_data, dout_sop, dout_eop}),
                                            64'(prev_out));
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL unexpected_pixel: got %0h expected none", {dout_data, dout_sop, dout_eop});
        end else begin
          pix_t p;
          p = exp_q.pop_front();
          check($sformatf("pixel[%0d]", xfers), 64'({dout_data, dout_sop, dout_eop}), 64'(p));
        end
        xfers++;
      end
      stalled_prev = dout_valid && !dout_ready;
      prev_out     = {dout_data, dout_sop, dout_eop};
      if (done) begin
        done_cnt++;
        check("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  task automatic push_expect(input logic [31:0] addr, input int num);
    int off, words;
    logic [31:0] base, a, w;
    off  = int'(addr[1:0]) * 8;
    base = addr & ~32'h3;
    for (int i = 0; i < num; i++) begin
      pix_t p;
      int g;
      g = off + i;
      w = mem_word(base + 32'(4 * (g / PPW)));
      p.d = w[(g % PPW) * PW +: PW];
      p.sop = (i == 0);
      p.eop = (i == num - 1);
      exp_q.push_back(p);
    end
    words = (off + num + PPW - 1) / PPW;
    a = base;
    while (words > 0) begin
      bur_t b;
      b.a  = a;
      b.bc = (BURST_LOG+1)'((words > MAXB) ? MAXB : words);
      bur_q.push_back(b);
      a += 32'(4 * int'(b.bc));
      words -= int'(b.bc);
    end
    words_req = 0; xfers = 0; off_pix_tb = off;
  endtask

  task automatic start_frame(input logic [31:0] addr, input int num);
    @(posedge clk); #1;
    start = 1'b1; frame_addr = addr; frame_num = 32'(num);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int limit);
    bit got = 0;
    for (int c = 0; c < limit && !got; c++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    check({name, "_done_seen"}, 64'(got), 64'd1);
    @(negedge clk);
  endtask

  task automatic end_checks(input string name, input int dc0);
    check({name, "_pixels_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_bursts_left"}, 64'(bur_q.size()), 64'd0);
    check({name, "_done_count"}, 64'(done_cnt - dc0), 64'd1);
    check({name, "_busy_after"}, 64'(busy), 64'd0);
  endtask

  task automatic run_frame(input string name, input logic [31:0] addr, input int num,
                           input int limit);
    int dc0;
    dc0 = done_cnt;
    push_expect(addr, num);
    start_frame(addr, num);
    wait_done(name, limit);
    end_checks(name, dc0);
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({busy, done, am_address, am_read, am_burstcount, am_byteenable, dout_data,
                dout_valid, dout_sop, dout_eop});
  endfunction

  initial begin
    int dc0, acc0;
    rst_n = 1'b0; start = 1'b0; frame_addr = '0; frame_num = '0;
    dout_ready = 1'b1; am_waitrequest = 1'b0; am_readdatavalid = 1'b0; am_readdata = '0;
    repeat (3) @(negedge clk);
    check("reset_outputs", all_outs(), 64'd0);
    @(posedge clk); #1 rst_n = 1'b1;

    run_frame("bits64", 32'h1000, 64, 500);
    run_frame("offset16", 32'h1002, 20, 500);

    mem_mode = 1; mem_base = 32'h2000;
    run_frame("bursts8881", 32'h2000, 800, 2000);
    mem_mode = 0;

    // Long downstream stall mid-frame.
    dc0 = done_cnt;
    push_expect(32'h3000, 1000);
    start_frame(32'h3000, 1000);
    fork
      wait_done("stall", 5000);
      begin
        repeat (60) @(posedge clk);
        rdy_mode = 2;
        repeat (100) @(posedge clk);
        rdy_mode = 0;
      end
    join
    end_checks("stall", dc0);

    slv_rand = 1; rdy_mode = 1;
    run_frame("random", 32'h4001, 1000, 20000);
    slv_rand = 0; rdy_mode = 0;
    repeat (15) @(posedge clk);

    // Empty frame: done next cycle, no bus traffic.
    dc0 = done_cnt; acc0 = acc_cnt;
    start_frame(32'h5000, 0);
    @(negedge clk);
    check("empty_done", 64'(done), 64'd1);
    check("empty_busy", 64'(busy), 64'd0);
    repeat (4) @(negedge clk);
    check("empty_no_read", 64'(acc_cnt - acc0), 64'd0);
    check("empty_done_count", 64'(done_cnt - dc0), 64'd1);

    run_frame("single", 32'h5003, 1, 200);

    // Start while busy must be ignored.
    dc0 = done_cnt;
    push_expect(32'h6000, 300);
    start_frame(32'h6000, 300);
    fork
      wait_done("busy_start", 2000);
      begin
        repeat (10) @(posedge clk); #1;
        start = 1'b1; frame_addr = 32'h7000; frame_num = 32'd50;
        @(posedge clk); #1 start = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    end_checks("busy_start", dc0);

    // Reset mid-frame, then a clean frame.
    push_expect(32'h8000, 500);
    start_frame(32'h8000, 500);
    repeat (30) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("midreset_outputs", all_outs(), 64'd0);
    exp_q.delete(); bur_q.delete(); beat_q.delete(); gap = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_frame("after_reset", 32'h8004, 100, 1000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
